tx_frame_buffer: RTL and testbench

Store-and-forward frame buffer on the 10G transmit path, between the user TX AXI4-Stream and the MAC transmit interface, in the clk156 domain. Accepts 64-bit AXI4-Stream frames with arbitrary input gaps and releases a frame only once its last word is stored. The released frame then goes out back-to-back with no tvalid gaps, because the MAC underruns on a mid-frame gap. Frames larger than the buffer are discarded whole and flagged. This is the transmit-side counterpart of the receive interface, which drops bad frames.

---
 rtl/tx_frame_buffer.sv | 181 ++++++++++++++++++
 tb/tb_tx_frame_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_buffer.sv
// Store-and-forward TX frame buffer, clk156 domain.
// Holds whole AXI4-Stream frames and releases each only after its tlast
// word is stored, so a released frame leaves gapless toward the MAC.
// Frames too large for the buffer are discarded whole (oversize_drop pulse).
// Ports:
//   clk156, reset            clock, async active-high reset
//   s_axis_*                 64-bit input stream (tdata/tkeep/tvalid/tlast/tready)
//   m_axis_*                 64-bit output stream to the MAC
//   frames_stored            committed frames not yet fully read out
//   words_used               words written and not yet transferred on m_axis
//   oversize_drop            one-cycle pulse when an oversize frame is dropped
module tx_frame_buffer #(
    parameter int DEPTH_LOG2      = 9,
    parameter int MAX_FRAMES_LOG2 = 4
) (
    input  logic                       clk156,
    input  logic                       reset,
    input  logic [63:0]                s_axis_tdata,
    input  logic [7:0]                 s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [63:0]                m_axis_tdata,
    output logic [7:0]                 m_axis_tkeep,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [MAX_FRAMES_LOG2:0]   frames_stored,
    output logic [DEPTH_LOG2:0]        words_used,
    output logic                       oversize_drop
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int W     = 73;

    localparam logic [DEPTH_LOG2:0]      WORDS_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [MAX_FRAMES_LOG2:0] FRAMES_FULL = {1'b1, {MAX_FRAMES_LOG2{1'b0}}};

    typedef enum logic {ST_ACCEPT, ST_DROP} wr_state_t;

    wr_state_t state, state_nxt;

    logic [W-1:0] mem [0:DEPTH-1];

    // Pointers carry one lap bit above the address so that a buffer holding
    // DEPTH committed words is distinguishable from an empty one.
    logic [DEPTH_LOG2:0] wr_ptr, commit_ptr, rd_ptr;

    logic         wr_store, commit, oversize, s_fire;
    logic         m_fire, m_last_fire;
    logic         rd_issue, rd_vld;
    logic [W-1:0] rd_data;
    logic [W-1:0] ob0, ob1;
    logic [1:0]   ob_cnt;
    logic [2:0]   slots;

    // Write-side FSM: state register
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) state <= ST_ACCEPT;
        else       state <= state_nxt;
    end

    // Only the uncommitted partial frame fills the buffer: it can never fit.
    assign oversize = (state == ST_ACCEPT) && (words_used == WORDS_FULL)
                      && (frames_stored == '0);

    // Write-side FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ACCEPT: if (oversize) state_nxt = ST_DROP;
            ST_DROP:   if (s_fire && s_axis_tlast) state_nxt = ST_ACCEPT;
            default:   state_nxt = ST_ACCEPT;
        endcase
    end

    // Write-side FSM: outputs
    always_comb begin
        s_axis_tready = 1'b0;
        if (!reset) begin
            unique case (state)
                ST_ACCEPT: s_axis_tready = (words_used < WORDS_FULL)
                                           && (frames_stored < FRAMES_FULL);
                ST_DROP:   s_axis_tready = 1'b1;
                default:   s_axis_tready = 1'b0;
            endcase
        end
    end

    assign s_fire   = s_axis_tvalid && s_axis_tready;
    assign wr_store = s_fire && (state == ST_ACCEPT);
    assign commit   = wr_store && s_axis_tlast;

    always_ff @(posedge clk156) begin
        if (wr_store)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            oversize_drop <= 1'b0;
        end else begin
            oversize_drop <= oversize;
            if (oversize)      wr_ptr <= commit_ptr;
            else if (wr_store) wr_ptr <= wr_ptr + 1'b1;
            if (commit)        commit_ptr <= wr_ptr + 1'b1;
        end
    end

    assign m_fire      = m_axis_tvalid && m_axis_tready;
    assign m_last_fire = m_fire && m_axis_tlast;

    // Read credit: entries held + read in flight, minus the entry leaving now.
    assign slots    = {1'b0, ob_cnt} + {2'b0, rd_vld} - {2'b0, m_fire};
    assign rd_issue = (rd_ptr != commit_ptr) && (slots < 3'd2);

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld <= rd_issue;
            if (rd_issue) begin
                rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

    // Two-entry output stage; ob0 is the head presented on m_axis.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            ob0    <= '0;
            ob1    <= '0;
            ob_cnt <= 2'd0;
        end else begin
            case (ob_cnt)
                2'd0: if (rd_vld) begin
                    ob0    <= rd_data;
                    ob_cnt <= 2'd1;
                end
                2'd1: if (rd_vld && m_fire) begin
                    ob0 <= rd_data;
                end else if (rd_vld) begin
                    ob1    <= rd_data;
                    ob_cnt <= 2'd2;
                end else if (m_fire) begin
                    ob_cnt <= 2'd0;
                end
                2'd2: if (m_fire) begin
                    ob0 <= ob1;
                    if (rd_vld) ob1 <= rd_data;
                    else        ob_cnt <= 2'd1;
                end
                default: ob_cnt <= 2'd0;
            endcase
        end
    end

    assign m_axis_tvalid = (ob_cnt != 2'd0);
    assign m_axis_tlast  = ob0[72];
    assign m_axis_tkeep  = ob0[71:64];
    assign m_axis_tdata  = ob0[63:0];

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            words_used    <= '0;
            frames_stored <= '0;
        end else begin
            if (oversize) words_used <= '0;
            else if (wr_store && !m_fire) words_used <= words_used + 1'b1;
            else if (!wr_store && m_fire) words_used <= words_used - 1'b1;
            if (commit && !m_last_fire)      frames_stored <= frames_stored + 1'b1;
            else if (!commit && m_last_fire) frames_stored <= frames_stored - 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Scoreboard bench for tx_frame_buffer: one default-depth instance and
// one 16-word instance for the oversize and exact-fill cases.
module tb_tx_frame_buffer;

    logic clk156 = 1'b0;
    logic reset;

    logic [63:0] s_tdata  [2];
    logic [7:0]  s_tkeep  [2];
    logic        s_tvalid [2];
    logic        s_tlast  [2];
    logic        s_tready [2];
    logic [63:0] m_tdata  [2];
    logic [7:0]  m_tkeep  [2];
    logic        m_tvalid [2];
    logic        m_tlast  [2];
    logic        m_tready [2];
    logic [4:0]  fs       [2];
    logic        ovf      [2];
    logic [9:0]  wu0;
    logic [4:0]  wu1;

    int errors = 0;
    int checks = 0;
    int ovf_cnt [2];
    bit rnd_rdy [2];
    logic [72:0] q0[$];
    logic [72:0] q1[$];

    initial forever #5 clk156 = ~clk156;

    tx_frame_buffer #(.DEPTH_LOG2(9), .MAX_FRAMES_LOG2(4)) dut0 (
        .clk156(clk156), .reset(reset),
        .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]),
        .s_axis_tvalid(s_tvalid[0]), .s_axis_tlast(s_tlast[0]),
        .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tlast(m_tlast[0]),
        .m_axis_tready(m_tready[0]),
        .frames_stored(fs[0]), .words_used(wu0), .oversize_drop(ovf[0])
    );

    tx_frame_buffer #(.DEPTH_LOG2(4), .MAX_FRAMES_LOG2(4)) dut1 (
        .clk156(clk156), .reset(reset),
        .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]),
        .s_axis_tvalid(s_tvalid[1]), .s_axis_tlast(s_tlast[1]),
        .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tlast(m_tlast[1]),
        .m_axis_tready(m_tready[1]),
        .frames_stored(fs[1]), .words_used(wu1), .oversize_drop(ovf[1])
    );

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [72:0] mk(input int id, input int i,
                                       input bit last, input logic [7:0] lk);
        logic [63:0] d;
        d = {id[15:0], 16'hBEEF, i[31:0] ^ 32'h5A5A0000};
        return {last, (last ? lk : 8'hFF), d};
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [72:0] qpop(input int sel);
        if (sel == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic put(input int sel, input logic [72:0] w);
        if (sel == 0) q0.push_back(w);
        else          q1.push_back(w);
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    task automatic set_rdy(input int sel, input logic v);
        @(posedge clk156);
        #1;
        m_tready[sel] = v;
    endtask

    task automatic send_word(input int sel, input logic [72:0] w, input bit exp);
        int n;
        n = 0;
        @(negedge clk156);
        s_tvalid[sel] = 1'b1;
        {s_tlast[sel], s_tkeep[sel], s_tdata[sel]} = w;
        while (!s_tready[sel]) begin
            n++;
            if (n > 3000) begin
                errors++;
                checks++;
                $display("FAIL s_tready_timeout: got 0 expected 1 (inst %0d)", sel);
                summary();
                $fatal(1, "s_tready stuck low");
            end
            @(negedge clk156);
        end
        if (exp) put(sel, w);
        @(posedge clk156);
        #1;
        s_tvalid[sel] = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int id, input int n,
                              input logic [7:0] lk, input bit gap,
                              input bit exp, input bit quiet);
        for (int i = 0; i < n; i++) begin
            if (quiet) chk("quiet_before_tlast", 80'(m_tvalid[sel]), 80'(0));
            send_word(sel, mk(id, i, (i == n - 1), lk), exp);
            if (gap) @(negedge clk156);
        end
    endtask

    task automatic drain(input int sel);
        int n;
        n = 0;
        while (qsize(sel) != 0 && n < 4000) begin
            @(negedge clk156);
            n++;
        end
        repeat (4) @(negedge clk156);
        chk("drained", 80'(qsize(sel)), 80'(0));
        chk("frames_stored_idle", 80'(fs[sel]), 80'(0));
        chk("words_used_idle", (sel == 0) ? 80'(wu0) : 80'(wu1), 80'(0));
    endtask

    initial forever begin
        @(posedge clk156);
        #1;
        for (int i = 0; i < 2; i++)
            if (rnd_rdy[i]) m_tready[i] = ($urandom_range(0, 1) == 1);
    end

    // Monitor: pops the scoreboard on every m_axis transfer and checks
    // gapless frames and stability under backpressure.
    initial begin
        bit          inf [2];
        bit          pv  [2];
        logic [72:0] pw  [2];
        logic [72:0] act;
        for (int i = 0; i < 2; i++) begin
            inf[i] = 0;
            pv[i]  = 0;
            pw[i]  = '0;
        end
        forever begin
            @(negedge clk156);
            for (int i = 0; i < 2; i++) begin
                act = {m_tlast[i], m_tkeep[i], m_tdata[i]};
                if (reset) begin
                    inf[i] = 0;
                    pv[i]  = 0;
                end else begin
                    if (ovf[i]) ovf_cnt[i]++;
                    if (inf[i]) chk("no_tvalid_gap", 80'(m_tvalid[i]), 80'(1));
                    if (pv[i])
                        chk("hold_stable", {7'd0, m_tvalid[i], act},
                            {7'd0, 1'b1, pw[i]});
                    if (m_tvalid[i] && m_tready[i]) begin
                        if (qsize(i) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat: got %h expected none (inst %0d)",
                                     act, i);
                        end else begin
                            chk("beat_data", 80'(act), 80'(qpop(i)));
                        end
                        inf[i] = !m_tlast[i];
                    end
                    pv[i] = m_tvalid[i] && !m_tready[i];
                    pw[i] = act;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_tdata[i]  = '0;
            s_tkeep[i]  = '0;
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            m_tready[i] = 1'b0;
            rnd_rdy[i]  = 0;
            ovf_cnt[i]  = 0;
        end
        repeat (3) @(negedge clk156);
        chk("rst_m_tvalid", 80'(m_tvalid[0]), 80'(0));
        chk("rst_s_tready", 80'(s_tready[0]), 80'(0));
        chk("rst_counters", {70'd0, fs[0], wu1}, 80'(0));
        chk("rst_words_used", 80'(wu0), 80'(0));
        chk("rst_m_word", {m_tlast[0], m_tkeep[0], m_tdata[0]}, 80'(0));
        chk("rst_ovf", 80'(ovf[0]), 80'(0));
        @(negedge clk156);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {78'd0, s_tready[1], s_tready[0]}, 80'(3));

        // Single 8-word frame, latency tlast -> tvalid is two edges
        set_rdy(0, 1'b1);
        send_frame(0, 1, 8, 8'h0F, 0, 1, 1);
        chk("fs_after_commit", 80'(fs[0]), 80'(1));
        chk("lat_edge_n", 80'(m_tvalid[0]), 80'(0));
        @(posedge clk156);
        #1;
        chk("lat_edge_n1", 80'(m_tvalid[0]), 80'(0));
        @(posedge clk156);
        #1;
        chk("lat_edge_n2", 80'(m_tvalid[0]), 80'(1));
        drain(0);

        // Gappy 32-word input
        send_frame(0, 2, 32, 8'hFF, 1, 1, 1);
        drain(0);

        // Frame limit with MAC stalled, then random backpressure
        set_rdy(0, 1'b0);
        for (int f = 0; f < 16; f++) send_frame(0, 10 + f, 2, 8'h03, 0, 1, 0);
        @(negedge clk156);
        chk("frames_full", 80'(fs[0]), 80'(16));
        chk("ready_low_at_16", 80'(s_tready[0]), 80'(0));
        fork
            send_frame(0, 26, 2, 8'h03, 0, 1, 0);
            begin
                repeat (5) @(posedge clk156);
                rnd_rdy[0] = 1;
            end
        join
        drain(0);
        rnd_rdy[0] = 0;
        set_rdy(0, 1'b1);

        // Oversize drop on the 16-word instance
        set_rdy(1, 1'b1);
        send_frame(1, 40, 20, 8'hFF, 0, 0, 1);
        send_frame(1, 41, 3, 8'h00, 0, 1, 0);
        drain(1);
        chk("oversize_pulses", 80'(ovf_cnt[1]), 80'(1));

        // Exact fill commits
        send_frame(1, 42, 16, 8'hAA, 0, 1, 1);
        drain(1);
        chk("exact_fill_no_drop", 80'(ovf_cnt[1]), 80'(1));

        // Commit of B on the same edge as tlast transfer of A
        set_rdy(0, 1'b0);
        send_frame(0, 50, 2, 8'h01, 0, 1, 0);
        for (int i = 0; i < 3; i++) send_word(0, mk(51, i, 0, 8'h00), 1);
        repeat (4) @(posedge clk156);
        set_rdy(0, 1'b1);
        set_rdy(0, 1'b0);
        repeat (2) @(posedge clk156);
        set_rdy(0, 1'b1);
        send_word(0, mk(51, 3, 1, 8'h3C), 1);
        m_tready[0] = 1'b0;
        chk("fs_simultaneous", 80'(fs[0]), 80'(1));
        chk("wu_simultaneous", 80'(wu0), 80'(4));

        // Reset in the middle of frame B output
        set_rdy(0, 1'b1);
        repeat (2) @(posedge clk156);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_tvalid", 80'(m_tvalid[0]), 80'(0));
        chk("midrst_fs", 80'(fs[0]), 80'(0));
        chk("midrst_wu", 80'(wu0), 80'(0));
        chk("midrst_s_tready", 80'(s_tready[0]), 80'(0));
        chk("midrst_m_word", {m_tlast[0], m_tkeep[0], m_tdata[0]}, 80'(0));
        chk("midrst_b_in_flight", 80'(q0.size() < 4), 80'(1));
        q0.delete();
        @(negedge clk156);
        reset = 1'b0;
        #1;
        chk("ready_after_midrst", 80'(s_tready[0]), 80'(1));
        send_frame(0, 60, 4, 8'hF0, 0, 1, 1);
        drain(0);

        summary();
        $finish;
    end

endmodule
